// File: rtl/result_fmt.sv
// result_fmt: turns one ASCII-offset result byte into a decimal ASCII string
// (optional '-', digits without leading zeros, terminator) and streams it one
// character at a time over a strobe/ack interface.
module result_fmt #(
    parameter bit         SIGNED = 1'b1,
    parameter logic [7:0] TERM   = 8'h0A
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       IN_STB,
    input  logic [7:0] IN_CHAR,
    output logic       IN_ACK,
    output logic       OUT_STB,
    output logic [7:0] OUT_CHAR,
    input  logic       OUT_ACK,
    output logic       BUSY
);

    typedef enum logic [1:0] {IDLE, CONV, EMIT} state_t;

    state_t     state_q, state_d;
    logic       armed_q, armed_d;
    logic       in_ack_q, in_ack_d;
    logic       out_stb_q, out_stb_d;
    logic [7:0] out_char_q, out_char_d;
    logic       busy_q, busy_d;
    logic       neg_q, neg_d;
    logic [7:0] mag_q, mag_d;
    logic [1:0] h_q, h_d;
    logic [3:0] t_q, t_d;
    logic [7:0] seq_q [5];
    logic [7:0] seq_d [5];
    logic [2:0] idx_q, idx_d;
    logic [2:0] last_q, last_d;

    // Captured value with the ASCII offset removed (8-bit wrap).
    logic [7:0] cap_v;
    assign cap_v = IN_CHAR - 8'h30;

    // Candidate string assembled from the finished counters; only loaded
    // into the emit buffer on the last conversion step, when mag_q < 10.
    logic [7:0] seq_b [5];
    logic [2:0] pos_b;
    logic [2:0] idx_nx;

    assign idx_nx = idx_q + 3'd1;

    // Assemble '-', hundreds, tens, units, terminator without leading zeros.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            seq_b[i] = TERM;
        end
        pos_b = 3'd0;
        if (neg_q) begin
            seq_b[pos_b] = 8'h2D;
            pos_b = pos_b + 3'd1;
        end
        if (h_q != 2'd0) begin
            seq_b[pos_b] = 8'h30 + {6'd0, h_q};
            pos_b = pos_b + 3'd1;
        end
        if ((h_q != 2'd0) || (t_q != 4'd0)) begin
            seq_b[pos_b] = 8'h30 + {4'd0, t_q};
            pos_b = pos_b + 3'd1;
        end
        seq_b[pos_b] = 8'h30 + {4'd0, mag_q[3:0]};
        pos_b = pos_b + 3'd1;
    end

    // State register and all datapath flops.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= IDLE;
            armed_q    <= 1'b0;
            in_ack_q   <= 1'b0;
            out_stb_q  <= 1'b0;
            out_char_q <= 8'h00;
            busy_q     <= 1'b0;
            neg_q      <= 1'b0;
            mag_q      <= 8'h00;
            h_q        <= 2'd0;
            t_q        <= 4'd0;
            idx_q      <= 3'd0;
            last_q     <= 3'd0;
            for (int i = 0; i < 5; i++) begin
                seq_q[i] <= 8'h00;
            end
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            in_ack_q   <= in_ack_d;
            out_stb_q  <= out_stb_d;
            out_char_q <= out_char_d;
            busy_q     <= busy_d;
            neg_q      <= neg_d;
            mag_q      <= mag_d;
            h_q        <= h_d;
            t_q        <= t_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            for (int i = 0; i < 5; i++) begin
                seq_q[i] <= seq_d[i];
            end
        end
    end

    // Next-state logic: capture, repeated-subtraction conversion, emission.
    always_comb begin
        state_d    = state_q;
        armed_d    = armed_q;
        in_ack_d   = 1'b0;
        out_stb_d  = out_stb_q;
        out_char_d = out_char_q;
        busy_d     = busy_q;
        neg_d      = neg_q;
        mag_d      = mag_q;
        h_d        = h_q;
        t_d        = t_q;
        idx_d      = idx_q;
        last_d     = last_q;
        for (int i = 0; i < 5; i++) begin
            seq_d[i] = seq_q[i];
        end
        case (state_q)
            IDLE: begin
                // A strobe only counts once it has been seen low, so a level
                // held across reset or a finished string is not re-taken.
                if (!IN_STB) begin
                    armed_d = 1'b1;
                end
                if (IN_STB && armed_q) begin
                    armed_d  = 1'b0;
                    in_ack_d = 1'b1;
                    busy_d   = 1'b1;
                    neg_d    = SIGNED && cap_v[7];
                    mag_d    = (SIGNED && cap_v[7]) ? (~cap_v + 8'd1) : cap_v;
                    h_d      = 2'd0;
                    t_d      = 4'd0;
                    state_d  = CONV;
                end
            end
            CONV: begin
                if (mag_q >= 8'd100) begin
                    mag_d = mag_q - 8'd100;
                    h_d   = h_q + 2'd1;
                end else if (mag_q >= 8'd10) begin
                    mag_d = mag_q - 8'd10;
                    t_d   = t_q + 4'd1;
                end else begin
                    for (int i = 0; i < 5; i++) begin
                        seq_d[i] = seq_b[i];
                    end
                    last_d     = pos_b;
                    idx_d      = 3'd0;
                    out_char_d = seq_b[0];
                    out_stb_d  = 1'b1;
                    state_d    = EMIT;
                end
            end
            EMIT: begin
                if (out_stb_q && OUT_ACK) begin
                    if (idx_q == last_q) begin
                        out_stb_d = 1'b0;
                        busy_d    = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        idx_d      = idx_nx;
                        out_char_d = seq_q[idx_nx];
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs come straight from registers.
    always_comb begin
        IN_ACK   = in_ack_q;
        OUT_STB  = out_stb_q;
        OUT_CHAR = out_char_q;
        BUSY     = busy_q;
    end

endmodule
